// File: rtl/hall_conditioner.sv
// Hall-sensor front end: sync, debounce, 6-step sector decode, direction, fault, period.
// Optional macro HALL_SKIP_FAULT_EN: flag a non-adjacent sector jump as a fault.
module hall_conditioner #(
    parameter int DEB_CYCLES = 16,
    parameter int PER_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             H1,
    input  logic             H2,
    input  logic             H3,
    input  logic             FLT_CLR,
    output logic [2:0]       H_OUT,
    output logic [2:0]       STEP,
    output logic             VALID,
    output logic             EDGE,
    output logic             DIR,
    output logic             FAULT,
    output logic [PER_W-1:0] PERIOD,
    output logic             PER_VALID,
    output logic             STALL
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(DEB_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_MAX = '1;
    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       cand;
    logic [CW-1:0]    stab_cnt;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] per_cnt_nxt;

    logic             accept;
    logic             cand_legal;
    logic [2:0]       cand_sec;
    logic [2:0]       step_fwd;
    logic [2:0]       step_rev;
    logic             restart;
    logic             fault_set;
    logic [2:0]       hout_nxt;
    logic [2:0]       step_nxt;
    logic             valid_nxt;
    logic             edge_nxt;
    logic             dir_nxt;
    logic [PER_W-1:0] period_nxt;
    logic             perv_nxt;

    // Two-flop synchroniser for the raw hall pins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {H3, H2, H1};
            sync2 <= sync1;
        end
    end

    // Candidate register with saturating stability counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cand     <= 3'b000;
            stab_cnt <= '0;
        end else if (sync2 != cand) begin
            cand     <= sync2;
            stab_cnt <= '0;
        end else if (stab_cnt != CNT_TOP) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    assign accept = (sync2 == cand) && (stab_cnt == CNT_TOP) && (cand != H_OUT);

    // Decode the candidate code to its forward-order sector
    always_comb begin
        cand_legal = 1'b1;
        cand_sec   = 3'd0;
        unique case (cand)
            3'b001:  cand_sec = 3'd0;
            3'b101:  cand_sec = 3'd1;
            3'b100:  cand_sec = 3'd2;
            3'b110:  cand_sec = 3'd3;
            3'b010:  cand_sec = 3'd4;
            3'b011:  cand_sec = 3'd5;
            default: cand_legal = 1'b0;
        endcase
    end

    assign step_fwd = (STEP == 3'd5) ? 3'd0 : STEP + 3'd1;
    assign step_rev = (STEP == 3'd0) ? 3'd5 : STEP - 3'd1;

    // Lock state machine: next state and next output values
    always_comb begin
        state_nxt  = state;
        hout_nxt   = H_OUT;
        step_nxt   = STEP;
        valid_nxt  = VALID;
        edge_nxt   = 1'b0;
        dir_nxt    = DIR;
        period_nxt = PERIOD;
        perv_nxt   = PER_VALID;
        restart    = 1'b0;
        fault_set  = 1'b0;
        if (accept) begin
            hout_nxt = cand;
            if (!cand_legal) begin
                valid_nxt = 1'b0;
                fault_set = 1'b1;
                perv_nxt  = 1'b0;
                state_nxt = UNLOCKED;
            end else begin
                valid_nxt = 1'b1;
                step_nxt  = cand_sec;
                restart   = 1'b1;
                state_nxt = LOCKED;
                if (state == LOCKED) begin
                    if (cand_sec == step_fwd) begin
                        edge_nxt   = 1'b1;
                        dir_nxt    = 1'b1;
                        period_nxt = per_cnt;
                        perv_nxt   = 1'b1;
                    end else if (cand_sec == step_rev) begin
                        edge_nxt   = 1'b1;
                        dir_nxt    = 1'b0;
                        period_nxt = per_cnt;
                        perv_nxt   = 1'b1;
`ifdef HALL_SKIP_FAULT_EN
                    end else begin
                        fault_set  = 1'b1;
`endif
                    end
                end
            end
        end
    end

    // Step-period counter restarts on any lock or sector change, else saturates
    always_comb begin
        per_cnt_nxt = per_cnt;
        if (restart) begin
            per_cnt_nxt = PER_ONE;
        end else if (per_cnt != PER_MAX) begin
            per_cnt_nxt = per_cnt + PER_ONE;
        end
    end

    // Registered state and outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= UNLOCKED;
            per_cnt   <= '0;
            H_OUT     <= 3'b000;
            STEP      <= 3'd0;
            VALID     <= 1'b0;
            EDGE      <= 1'b0;
            DIR       <= 1'b1;
            FAULT     <= 1'b0;
            PERIOD    <= '0;
            PER_VALID <= 1'b0;
            STALL     <= 1'b0;
        end else begin
            state     <= state_nxt;
            per_cnt   <= per_cnt_nxt;
            H_OUT     <= hout_nxt;
            STEP      <= step_nxt;
            VALID     <= valid_nxt;
            EDGE      <= edge_nxt;
            DIR       <= dir_nxt;
            FAULT     <= fault_set | (FAULT & ~FLT_CLR);
            PERIOD    <= period_nxt;
            PER_VALID <= perv_nxt;
            STALL     <= (per_cnt_nxt == PER_MAX);
        end
    end

endmodule

// File: tb/tb_hall_conditioner.sv
// Self-checking bench for hall_conditioner (DEB_CYCLES=4, PER_W=16).
// Window-based reference model plus directed vectors; honours HALL_SKIP_FAULT_EN.
module tb_hall_conditioner;

    localparam int DEB  = 4;
    localparam int PW   = 16;
    localparam int PMAX = 65535;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [2:0]    hall;
    logic          FLT_CLR;
    logic [2:0]    H_OUT;
    logic [2:0]    STEP;
    logic          VALID;
    logic          EDGE;
    logic          DIR;
    logic          FAULT;
    logic [PW-1:0] PERIOD;
    logic          PER_VALID;
    logic          STALL;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    hall_conditioner #(.DEB_CYCLES(DEB), .PER_W(PW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .H1(hall[0]), .H2(hall[1]), .H3(hall[2]),
        .FLT_CLR(FLT_CLR),
        .H_OUT(H_OUT), .STEP(STEP), .VALID(VALID), .EDGE(EDGE),
        .DIR(DIR), .FAULT(FAULT), .PERIOD(PERIOD),
        .PER_VALID(PER_VALID), .STALL(STALL)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [2:0]    hist [0:DEB+2];
    logic [2:0]    m_hout;
    logic [2:0]    m_step;
    logic          m_valid;
    logic          m_locked;
    logic          m_edge;
    logic          m_dir;
    logic          m_fault;
    logic [PW-1:0] m_period;
    logic          m_perv;
    logic          m_stall;
    longint        cyc;
    longint        m_restart;

    function automatic int sec_of(input logic [2:0] c);
        case (c)
            3'b001:  return 0;
            3'b101:  return 1;
            3'b100:  return 2;
            3'b110:  return 3;
            3'b010:  return 4;
            3'b011:  return 5;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= DEB + 2; k++) hist[k] = 3'b000;
        m_hout = 3'b000; m_step = 3'd0; m_valid = 1'b0; m_locked = 1'b0;
        m_edge = 1'b0; m_dir = 1'b1; m_fault = 1'b0; m_period = '0;
        m_perv = 1'b0; m_stall = 1'b0; cyc = 0; m_restart = 1;
    endtask

    // Model: accept a code once the last DEB+1 synchronised samples agree
    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                model_reset();
            end else begin
                logic   stable;
                int     s;
                int     ps;
                longint d;
                cyc++;
                for (int k = DEB + 2; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = hall;
                m_edge = 1'b0;
                stable = 1'b1;
                for (int k = 3; k <= DEB + 2; k++)
                    if (hist[k] != hist[2]) stable = 1'b0;
                if (FLT_CLR) m_fault = 1'b0;
                if (stable && hist[2] != m_hout) begin
                    s = sec_of(hist[2]);
                    m_hout = hist[2];
                    if (s < 0) begin
                        m_valid = 1'b0; m_fault = 1'b1;
                        m_perv = 1'b0; m_locked = 1'b0;
                    end else begin
                        if (m_locked) begin
                            ps = int'(m_step);
                            d = cyc - m_restart;
                            if (d > PMAX) d = PMAX;
                            if (s == (ps + 1) % 6) begin
                                m_edge = 1'b1; m_dir = 1'b1;
                                m_period = PW'(d); m_perv = 1'b1;
                            end else if (s == (ps + 5) % 6) begin
                                m_edge = 1'b1; m_dir = 1'b0;
                                m_period = PW'(d); m_perv = 1'b1;
                            end else begin
`ifdef HALL_SKIP_FAULT_EN
                                m_fault = 1'b1;
`endif
                            end
                        end
                        m_step = 3'(s); m_valid = 1'b1;
                        m_locked = 1'b1; m_restart = cyc;
                    end
                end
                m_stall = (cyc - m_restart + 1 >= PMAX);
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        logic [27:0] act;
        logic [27:0] exp;
        forever begin
            @(negedge CLK);
            act = {H_OUT, STEP, VALID, EDGE, DIR, FAULT, PER_VALID, STALL, PERIOD};
            exp = {m_hout, m_step, m_valid, m_edge, m_dir, m_fault, m_perv, m_stall, m_period};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL outputs cyc=%0d: got %h expected %h", cyc, act, exp);
            end
            if (EDGE === 1'b1) edge_cnt++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " H_OUT"}, int'(H_OUT), 0);
        chk({tag, " STEP"}, int'(STEP), 0);
        chk({tag, " VALID"}, int'(VALID), 0);
        chk({tag, " EDGE"}, int'(EDGE), 0);
        chk({tag, " DIR"}, int'(DIR), 1);
        chk({tag, " FAULT"}, int'(FAULT), 0);
        chk({tag, " PERIOD"}, int'(PERIOD), 0);
        chk({tag, " PER_VALID"}, int'(PER_VALID), 0);
        chk({tag, " STALL"}, int'(STALL), 0);
    endtask

    logic [2:0] fwd_codes [0:5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    int         fwd_steps [0:5] = '{1, 2, 3, 4, 5, 0};
    logic [2:0] rev_codes [0:5] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    int         rev_steps [0:5] = '{5, 4, 3, 2, 1, 0};

    initial begin
        int e0;
        RST_N = 1'b0;
        hall = 3'b000;
        FLT_CLR = 1'b0;
        wait_cyc(3);
        chk_reset_vals("reset");

        // Release and lock at 001: visible after the 7th edge, not the 6th
        RST_N = 1'b1;
        hall = 3'b001;
        wait_cyc(6);
        chk("latency H_OUT before", int'(H_OUT), 0);
        wait_cyc(1);
        chk("lock H_OUT", int'(H_OUT), 1);
        chk("lock STEP", int'(STEP), 0);
        chk("lock VALID", int'(VALID), 1);
        chk("lock EDGE", int'(EDGE), 0);
        chk("lock PER_VALID", int'(PER_VALID), 0);
        chk("lock model VALID", int'(m_valid), 1);

        // Forward rotation, 50 cycles per step
        for (int i = 0; i < 6; i++) begin
            e0 = edge_cnt;
            hall = fwd_codes[i];
            wait_cyc(50);
            chk("fwd STEP", int'(STEP), fwd_steps[i]);
            chk("fwd DIR", int'(DIR), 1);
            chk("fwd EDGE count", edge_cnt - e0, 1);
            if (i > 0) begin
                chk("fwd PERIOD", int'(PERIOD), 50);
                chk("fwd model PERIOD", int'(m_period), 50);
                chk("fwd PER_VALID", int'(PER_VALID), 1);
            end
        end

        // Reverse rotation
        for (int i = 0; i < 6; i++) begin
            e0 = edge_cnt;
            hall = rev_codes[i];
            wait_cyc(50);
            chk("rev STEP", int'(STEP), rev_steps[i]);
            chk("rev DIR", int'(DIR), 0);
            chk("rev EDGE count", edge_cnt - e0, 1);
            chk("rev PERIOD", int'(PERIOD), 50);
        end

        // 3-cycle glitch is rejected
        e0 = edge_cnt;
        hall = 3'b101;
        wait_cyc(3);
        hall = 3'b001;
        wait_cyc(20);
        chk("glitch H_OUT", int'(H_OUT), 1);
        chk("glitch EDGE count", edge_cnt - e0, 0);

        // Illegal code, relock, sticky fault and clear
        hall = 3'b111;
        wait_cyc(10);
        chk("illegal H_OUT", int'(H_OUT), 7);
        chk("illegal VALID", int'(VALID), 0);
        chk("illegal FAULT", int'(FAULT), 1);
        chk("illegal PER_VALID", int'(PER_VALID), 0);
        chk("illegal STEP hold", int'(STEP), 0);
        e0 = edge_cnt;
        hall = 3'b011;
        wait_cyc(20);
        chk("relock VALID", int'(VALID), 1);
        chk("relock STEP", int'(STEP), 5);
        chk("relock EDGE count", edge_cnt - e0, 0);
        chk("relock FAULT sticky", int'(FAULT), 1);
        chk("relock PERIOD kept", int'(PERIOD), 50);
        FLT_CLR = 1'b1;
        wait_cyc(1);
        FLT_CLR = 1'b0;
        wait_cyc(1);
        chk("flt_clr FAULT", int'(FAULT), 0);

        // Long hold saturates the period counter
        wait_cyc(66000);
        chk("stall STALL", int'(STALL), 1);
        chk("stall PERIOD kept", int'(PERIOD), 50);
        e0 = edge_cnt;
        hall = 3'b001;
        wait_cyc(10);
        chk("post-stall PERIOD", int'(PERIOD), 65535);
        chk("post-stall STALL", int'(STALL), 0);
        chk("post-stall DIR", int'(DIR), 1);
        chk("post-stall STEP wrap", int'(STEP), 0);
        chk("post-stall EDGE count", edge_cnt - e0, 1);

        // Non-adjacent jump 0 -> 2
        e0 = edge_cnt;
        hall = 3'b100;
        wait_cyc(10);
        chk("skip STEP", int'(STEP), 2);
        chk("skip EDGE count", edge_cnt - e0, 0);
        chk("skip DIR", int'(DIR), 1);
`ifdef HALL_SKIP_FAULT_EN
        chk("skip FAULT", int'(FAULT), 1);
`else
        chk("skip FAULT", int'(FAULT), 0);
`endif

        // Reset mid-debounce, then an unlocked lock after release
        hall = 3'b110;
        wait_cyc(3);
        RST_N = 1'b0;
        wait_cyc(2);
        chk_reset_vals("mid reset");
        RST_N = 1'b1;
        e0 = edge_cnt;
        wait_cyc(10);
        chk("post-reset VALID", int'(VALID), 1);
        chk("post-reset STEP", int'(STEP), 3);
        chk("post-reset EDGE count", edge_cnt - e0, 0);
        chk("post-reset PER_VALID", int'(PER_VALID), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
